// File: rtl/cla5_result_collector.sv
// cla5_result_collector
//   Downstream stage of cla5_pipelined. A shift register of issue tags
//   follows each operand set through the adder pipeline. When a tagged slot
//   reaches the adder output, the 6-bit result {cout_in, s_in} is captured
//   into a small FIFO. Results leave through a valid/ready port. The block
//   also keeps a saturating count of captured carry-out results and a sticky
//   flag for results dropped because the FIFO was full.
//
// Parameters
//   PIPE_LAT : cycles from operands at the adder input to result at its output
//   DEPTH    : result FIFO entries (power of 2, >= 2)
//   CNT_W    : width of carry_count
//
// Ports
//   clk          in   rising-edge clock, shared with the adder
//   rst_n        in   asynchronous active-low reset
//   issue_valid  in   operands driven to the adder this cycle are valid
//   s_in         in   adder sum output (5 bits)
//   cout_in      in   adder carry output
//   clear_stats  in   synchronous clear of carry_count and overflow_err
//   res_valid    out  FIFO head valid
//   res_ready    in   consumer accepts the head this cycle
//   res_sum      out  FIFO head {cout,s}; zero when empty
//   fifo_level   out  number of entries held
//   carry_count  out  accepted results with cout=1, saturating
//   overflow_err out  sticky: a result was dropped because the FIFO was full

module cla5_result_collector #(
  parameter int unsigned PIPE_LAT = 3,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       issue_valid,
  input  logic [4:0]                 s_in,
  input  logic                       cout_in,
  input  logic                       clear_stats,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [5:0]                 res_sum,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [CNT_W-1:0]           carry_count,
  output logic                       overflow_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  // ---------------------------------------------------------------------------
  // Tag pipe: one bit per adder stage, marking slots that carry valid operands.
  // ---------------------------------------------------------------------------
  logic [PIPE_LAT-1:0] r_tag;
  logic                w_cap;

  generate
    if (PIPE_LAT == 1) begin : g_tag_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_tag <= '0;
        else        r_tag <= issue_valid;
      end
    end else begin : g_tag_shift
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_tag <= '0;
        else        r_tag <= {r_tag[PIPE_LAT-2:0], issue_valid};
      end
    end
  endgenerate

  // The oldest tag lines up with the cycle in which s_in/cout_in hold that
  // slot's result.
  assign w_cap = r_tag[PIPE_LAT-1];

  // ---------------------------------------------------------------------------
  // Result FIFO
  // ---------------------------------------------------------------------------
  logic [5:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;

  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [5:0]    w_wdata;
  logic [LW-1:0] w_level_nxt;

  assign w_full  = (r_level == FULL_LEVEL);
  assign w_empty = (r_level == '0);
  assign w_pop   = res_valid & res_ready;
  // When full, a same-cycle pop frees the head slot, and wr_ptr == rd_ptr
  // points right at it, so the capture can still be accepted.
  assign w_push  = w_cap & (~w_full | w_pop);
  assign w_drop  = w_cap & w_full & ~w_pop;
  assign w_wdata = {cout_in, s_in};

  always_comb begin
    w_level_nxt = r_level;
    unique case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + LW'(1);
      2'b01:   w_level_nxt = r_level - LW'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  // Storage carries no reset: entries are only visible through the level,
  // which is cleared.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_wdata;
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= w_level_nxt;
    end
  end

  // Head is presented straight from storage; it only changes on a pop, so it
  // holds steady while the consumer stalls.
  assign res_valid  = ~w_empty;
  assign res_sum    = w_empty ? '0 : r_mem[r_rd_ptr];
  assign fifo_level = r_level;

  // ---------------------------------------------------------------------------
  // Statistics: clear has priority over a same-cycle increment or drop.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] r_carry_count;
  logic             r_overflow_err;
  logic             w_cnt_sat;

  assign w_cnt_sat = (r_carry_count == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_carry_count  <= '0;
      r_overflow_err <= 1'b0;
    end else if (clear_stats) begin
      r_carry_count  <= '0;
      r_overflow_err <= 1'b0;
    end else begin
      if (w_push && cout_in && !w_cnt_sat) r_carry_count <= r_carry_count + CNT_W'(1);
      if (w_drop)                          r_overflow_err <= 1'b1;
    end
  end

  assign carry_count  = r_carry_count;
  assign overflow_err = r_overflow_err;

endmodule

// File: tb/tb_cla5_result_collector.sv
// Directed bench for cla5_result_collector. A small behavioural model of the
// 3-stage adder feeds s_in/cout_in; a second instance with CNT_W=2 shares the
// stimulus to exercise carry_count saturation.

module tb_cla5_result_collector;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       issue_valid;
  logic [4:0] op_a;
  logic [4:0] op_b;
  logic       op_cin;
  logic       clear_stats;
  logic       res_ready;

  logic [4:0] s_in;
  logic       cout_in;

  logic       res_valid,   res_valid_s;
  logic [5:0] res_sum,     res_sum_s;
  logic [2:0] fifo_level,  fifo_level_s;
  logic [7:0] carry_count;
  logic [1:0] carry_count_s;
  logic       overflow_err, overflow_err_s;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Adder model: result of the operands present at edge N appears 3 edges later.
  logic [5:0] p0 = '0, p1 = '0, p2 = '0;
  always @(posedge clk) begin
    p0 <= {1'b0, op_a} + {1'b0, op_b} + {5'b0, op_cin};
    p1 <= p0;
    p2 <= p1;
  end
  assign s_in    = p2[4:0];
  assign cout_in = p2[5];

  cla5_result_collector #(.PIPE_LAT(3), .DEPTH(4), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .s_in(s_in),
    .cout_in(cout_in), .clear_stats(clear_stats), .res_valid(res_valid),
    .res_ready(res_ready), .res_sum(res_sum), .fifo_level(fifo_level),
    .carry_count(carry_count), .overflow_err(overflow_err)
  );

  cla5_result_collector #(.PIPE_LAT(3), .DEPTH(4), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .s_in(s_in),
    .cout_in(cout_in), .clear_stats(clear_stats), .res_valid(res_valid_s),
    .res_ready(res_ready), .res_sum(res_sum_s), .fifo_level(fifo_level_s),
    .carry_count(carry_count_s), .overflow_err(overflow_err_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one issue for a single cycle.
  task automatic drive_issue(input logic [4:0] a, input logic [4:0] b, input logic c);
    op_a = a; op_b = b; op_cin = c; issue_valid = 1'b1;
    @(negedge clk);
    issue_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; issue_valid = 1'b0; op_a = '0; op_b = '0; op_cin = 1'b0;
    clear_stats = 1'b0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(res_valid),    32'd0);
    check("rst_sum",   32'(res_sum),      32'd0);
    check("rst_level", 32'(fifo_level),   32'd0);
    check("rst_count", 32'(carry_count),  32'd0);
    check("rst_ovf",   32'(overflow_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single issue, latency PIPE_LAT+1
    drive_issue(5'd3, 5'd5, 1'b0);           // now in cycle 1
    repeat (2) @(negedge clk);               // cycle 3
    check("t1_valid_early", 32'(res_valid), 32'd0);
    @(negedge clk);                          // cycle 4
    check("t1_valid", 32'(res_valid),   32'd1);
    check("t1_sum",   32'(res_sum),     32'b001000);
    check("t1_count", 32'(carry_count), 32'd0);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("t1_empty_valid", 32'(res_valid), 32'd0);
    check("t1_empty_sum",   32'(res_sum),   32'd0);

    // 2: carry results
    drive_issue(5'd31, 5'd7, 1'b0);
    drive_issue(5'd28, 5'd28, 1'b1);         // cycle 2
    repeat (2) @(negedge clk);               // cycle 4
    check("t2_count1", 32'(carry_count), 32'd1);
    check("t2_head1",  32'(res_sum),     32'b100110);
    check("t2_level1", 32'(fifo_level),  32'd1);
    @(negedge clk);
    check("t2_count2", 32'(carry_count), 32'd2);
    check("t2_level2", 32'(fifo_level),  32'd2);
    check("t2_hold",   32'(res_sum),     32'b100110);
    res_ready = 1'b1;
    @(negedge clk);
    check("t2_head2", 32'(res_sum), 32'b111001);
    @(negedge clk);
    res_ready = 1'b0;
    check("t2_empty", 32'(res_valid), 32'd0);

    // 3: overflow with 5 issues into a 4-deep FIFO, then drain
    for (int k = 1; k <= 5; k++) drive_issue(5'(k), 5'(k), 1'b0);
    repeat (4) @(negedge clk);
    check("t3_level", 32'(fifo_level),   32'd4);
    check("t3_ovf",   32'(overflow_err), 32'd1);
    check("t3_count", 32'(carry_count),  32'd2);
    res_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("t3_drain%0d_valid", k), 32'(res_valid), 32'd1);
      check($sformatf("t3_drain%0d_sum", k),   32'(res_sum),   32'(2 * k));
      @(negedge clk);
    end
    res_ready = 1'b0;
    check("t3_end_valid", 32'(res_valid), 32'd0);
    check("t3_end_sum",   32'(res_sum),   32'd0);
    check("t3_ovf_sticky", 32'(overflow_err), 32'd1);
    clear_stats = 1'b1;
    @(negedge clk);
    clear_stats = 1'b0;
    check("t3_clr_ovf",   32'(overflow_err), 32'd0);
    check("t3_clr_count", 32'(carry_count),  32'd0);

    // 4: full FIFO with simultaneous push and pop; item k has sum k
    for (int c = 0; c <= 15; c++) begin
      if (c >= 7 && c <= 11) check($sformatf("t4_level_c%0d", c), 32'(fifo_level), 32'd4);
      if (c >= 7 && c <= 14) begin
        check($sformatf("t4_valid_c%0d", c), 32'(res_valid), 32'd1);
        check($sformatf("t4_sum_c%0d", c),   32'(res_sum),   32'(c - 6));
      end
      issue_valid = (c < 8);
      op_a = 5'(c + 1); op_b = '0; op_cin = 1'b0;
      res_ready = (c >= 7);
      @(negedge clk);
    end
    issue_valid = 1'b0; res_ready = 1'b0;
    check("t4_empty", 32'(res_valid),    32'd0);
    check("t4_ovf",   32'(overflow_err), 32'd0);

    // 5: async reset with 2 results queued and 2 in flight
    for (int k = 1; k <= 4; k++) drive_issue(5'(k), 5'd0, 1'b0);
    @(negedge clk);                          // cycle 5
    check("t5_pre_level", 32'(fifo_level), 32'd2);
    rst_n = 1'b0;
    #1;
    check("t5_valid", 32'(res_valid),   32'd0);
    check("t5_sum",   32'(res_sum),     32'd0);
    check("t5_level", 32'(fifo_level),  32'd0);
    check("t5_count", 32'(carry_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("t5_after%0d_valid", k), 32'(res_valid),  32'd0);
      check($sformatf("t5_after%0d_level", k), 32'(fifo_level), 32'd0);
    end

    // 6: clear wins over a same-cycle carry push; saturation at CNT_W=2
    drive_issue(5'd31, 5'd1, 1'b0);          // cycle 1
    repeat (2) @(negedge clk);               // cycle 3: capture cycle
    clear_stats = 1'b1;
    @(negedge clk);
    clear_stats = 1'b0;
    check("t6_clr_count", 32'(carry_count),   32'd0);
    check("t6_clr_count_s", 32'(carry_count_s), 32'd0);
    check("t6_level",     32'(fifo_level),    32'd1);
    check("t6_sum",       32'(res_sum),       32'b100000);
    res_ready = 1'b1;
    for (int k = 0; k < 5; k++) drive_issue(5'd31, 5'd1, 1'b0);
    repeat (4) @(negedge clk);
    check("t6_count5",  32'(carry_count),   32'd5);
    check("t6_sat",     32'(carry_count_s), 32'd3);
    check("t6_level0",  32'(fifo_level),    32'd0);
    check("t6_ovf",     32'(overflow_err),  32'd0);
    res_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
